// File: rtl/mem_wb_pipe_if.sv
// Handshake and payload bundle between the memory stage, mem_wb_pipe and the writeback port.
// master = upstream/writeback side, slave = the pipeline stage itself.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int SEL_W  = 4
);
    // Upstream (memory stage) side
    logic              in_valid_i;
    logic              in_ready_o;
    logic [RA_W-1:0]   wa_i;
    logic              we_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] dmemdata_i;
    logic [1:0]        byte_off_i;
    logic [SEL_W-1:0]  LD_sel_i;

    // Downstream (writeback) side
    logic              out_valid_o;
    logic              out_ready_i;
    logic [RA_W-1:0]   wa_o;
    logic              we_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [SEL_W-1:0]  LD_sel_o;

    modport master (
        output in_valid_i, wa_i, we_i, wdata_i, dmemdata_i, byte_off_i, LD_sel_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, wa_o, we_o, wb_data_o, LD_sel_o
    );

    modport slave (
        input  in_valid_i, wa_i, we_i, wdata_i, dmemdata_i, byte_off_i, LD_sel_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, wa_o, we_o, wb_data_o, LD_sel_o
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: two-entry skid buffer with valid/ready handshake and synchronous flush.
// Define MEM_WB_LOAD_ALIGN_EN to do load byte/halfword extraction and sign extension here.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int SEL_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    mem_wb_pipe_if.slave bus
);

    localparam logic [SEL_W-1:0] SEL_LB  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LH  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_LW  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_LBU = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_LHU = SEL_W'(5);

    typedef struct packed {
        logic [RA_W-1:0]   wa;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] dmem;
        logic [1:0]        off;
        logic [SEL_W-1:0]  sel;
    } entry_t;

    // EMPTY: nothing held, ONE: main only, TWO: main and skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   main_valid;
    logic   accept;
    logic   pop;

`ifdef MEM_WB_LOAD_ALIGN_EN
    function automatic logic [DATA_W-1:0] wb_select(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] dmem,
        input logic [1:0]        off
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = dmem[{off, 3'b000} +: 8];
        h = off[1] ? dmem[31:16] : dmem[15:0];
        case (sel)
            SEL_LB:  r = {{(DATA_W-8){b[7]}}, b};
            SEL_LBU: r = {{(DATA_W-8){1'b0}}, b};
            SEL_LH:  r = {{(DATA_W-16){h[15]}}, h};
            SEL_LHU: r = {{(DATA_W-16){1'b0}}, h};
            SEL_LW:  r = dmem;
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign bus.wb_data_o = wb_select(main_q.sel, main_q.wdata, main_q.dmem, main_q.off);
`else
    // Raw word goes through; the writeback side aligns using its own copy of the offset.
    function automatic logic [DATA_W-1:0] wb_select(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] dmem
    );
        logic [DATA_W-1:0] r;
        case (sel)
            SEL_LB, SEL_LH, SEL_LW, SEL_LBU, SEL_LHU: r = dmem;
            default:                                  r = wdata;
        endcase
        return r;
    endfunction

    logic unused_off;
    assign unused_off    = ^main_q.off;
    assign bus.wb_data_o = wb_select(main_q.sel, main_q.wdata, main_q.dmem);
`endif

    assign in_entry = '{
        wa:    bus.wa_i,
        we:    bus.we_i,
        wdata: bus.wdata_i,
        dmem:  bus.dmemdata_i,
        off:   bus.byte_off_i,
        sel:   bus.LD_sel_i
    };

    assign main_valid = (state_q != ST_EMPTY);

    // Flush masks the handshake so payload registers stay untouched on that edge.
    assign accept = bus.in_valid_i & in_ready_q & ~flush_i;
    assign pop    = main_valid & bus.out_ready_i & ~flush_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
        // Ready is precomputed for next cycle so it never depends on out_ready_i combinationally.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = main_valid;
    assign bus.we_o        = main_q.we & main_valid;
    assign bus.wa_o        = main_q.wa;
    assign bus.LD_sel_o    = main_q.sel;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: reset, streaming, backpressure, flush, load select, async reset.
// Expected load data follows MEM_WB_LOAD_ALIGN_EN when it is defined.
module tb_mem_wb_pipe;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int SEL_W  = 4;
    localparam logic [31:0] DMEM = 32'h80FF7F01;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_fail;

    mem_wb_pipe_if #(.DATA_W(DATA_W), .RA_W(RA_W), .SEL_W(SEL_W)) bus ();

    mem_wb_pipe #(.DATA_W(DATA_W), .RA_W(RA_W), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [RA_W-1:0] wa, input logic [31:0] wdata,
                         input logic [1:0] off, input logic [SEL_W-1:0] sel);
        bus.in_valid_i = v;
        bus.wa_i       = wa;
        bus.we_i       = 1'b1;
        bus.wdata_i    = wdata;
        bus.dmemdata_i = DMEM;
        bus.byte_off_i = off;
        bus.LD_sel_i   = sel;
    endtask

    task automatic ld_step(input string tag, input logic [SEL_W-1:0] sel, input logic [1:0] off,
                           input logic [31:0] wdata, input logic [31:0] exp_align);
        logic [31:0] exp;
`ifdef MEM_WB_LOAD_ALIGN_EN
        exp = exp_align;
`else
        exp = (sel >= 1 && sel <= 5) ? DMEM : wdata;
`endif
        drive(1'b1, 5'd11, wdata, off, sel);
        tick();
        chk({tag, "_data"}, 64'(bus.wb_data_o), 64'(exp));
        chk({tag, "_sel"}, 64'(bus.LD_sel_o), 64'(sel));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        flush  = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        bus.we_i = 1'b0;

        // Reset held three cycles
        repeat (3) tick();
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_we", 64'(bus.we_o), 64'd0);
        chk("rst_wa", 64'(bus.wa_o), 64'd0);
        chk("rst_wb", 64'(bus.wb_data_o), 64'd0);
        chk("rst_sel", 64'(bus.LD_sel_o), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.in_ready_o), 64'd1);

        // Back-to-back stream
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, RA_W'(i + 1), 32'h10 + 32'(i), 2'd0, 4'd0);
            tick();
            chk("strm_valid", 64'(bus.out_valid_o), 64'd1);
            chk("strm_wa", 64'(bus.wa_o), 64'(i + 1));
            chk("strm_wb", 64'(bus.wb_data_o), 64'h10 + 64'(i));
            chk("strm_we", 64'(bus.we_o), 64'd1);
        end
        bus.in_valid_i = 1'b0;
        tick();
        chk("strm_drain", 64'(bus.out_valid_o), 64'd0);

        // Backpressure: two accepted, third held off
        bus.out_ready_i = 1'b0;
        drive(1'b1, 5'd5, 32'h20, 2'd0, 4'd0);
        tick();
        chk("bp_rdy1", 64'(bus.in_ready_o), 64'd1);
        drive(1'b1, 5'd6, 32'h21, 2'd0, 4'd0);
        tick();
        chk("bp_rdy2", 64'(bus.in_ready_o), 64'd0);
        chk("bp_head", 64'(bus.wa_o), 64'd5);
        drive(1'b1, 5'd7, 32'h22, 2'd0, 4'd0);
        tick();
        chk("bp_hold_rdy", 64'(bus.in_ready_o), 64'd0);
        chk("bp_hold_wa", 64'(bus.wa_o), 64'd5);
        chk("bp_hold_wb", 64'(bus.wb_data_o), 64'h20);
        bus.out_ready_i = 1'b1;
        tick();
        chk("bp_pop1_wa", 64'(bus.wa_o), 64'd6);
        chk("bp_pop1_wb", 64'(bus.wb_data_o), 64'h21);
        chk("bp_pop1_rdy", 64'(bus.in_ready_o), 64'd1);
        tick();
        chk("bp_pop2_wa", 64'(bus.wa_o), 64'd7);
        chk("bp_pop2_wb", 64'(bus.wb_data_o), 64'h22);
        chk("bp_pop2_vld", 64'(bus.out_valid_o), 64'd1);
        bus.in_valid_i = 1'b0;
        tick();
        chk("bp_empty", 64'(bus.out_valid_o), 64'd0);

        // Flush with both entries held and a new entry offered
        bus.out_ready_i = 1'b0;
        drive(1'b1, 5'd8, 32'h30, 2'd0, 4'd0);
        tick();
        drive(1'b1, 5'd9, 32'h31, 2'd0, 4'd0);
        tick();
        chk("fl_full", 64'(bus.in_ready_o), 64'd0);
        flush = 1'b1;
        bus.out_ready_i = 1'b1;
        drive(1'b1, 5'd10, 32'h32, 2'd0, 4'd0);
        tick();
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("fl_valid", 64'(bus.out_valid_o), 64'd0);
        chk("fl_we", 64'(bus.we_o), 64'd0);
        chk("fl_rdy", 64'(bus.in_ready_o), 64'd1);
        tick();
        chk("fl_noacc", 64'(bus.out_valid_o), 64'd0);

        // Load selection (dmem = 80FF7F01)
        bus.out_ready_i = 1'b1;
        ld_step("lb3",  4'd1, 2'd3, 32'h0, 32'hFFFFFF80);
        ld_step("lbu3", 4'd4, 2'd3, 32'h0, 32'h00000080);
        ld_step("lh2",  4'd2, 2'd2, 32'h0, 32'hFFFF80FF);
        ld_step("lhu0", 4'd5, 2'd0, 32'h0, 32'h00007F01);
        ld_step("lw",   4'd3, 2'd0, 32'h0, 32'h80FF7F01);
        ld_step("lb0",  4'd1, 2'd0, 32'h0, 32'h00000001);
        ld_step("lb2",  4'd1, 2'd2, 32'h0, 32'hFFFFFFFF);
        ld_step("lh3",  4'd2, 2'd3, 32'h0, 32'hFFFF80FF);
        ld_step("lhu2", 4'd5, 2'd2, 32'h0, 32'h000080FF);
        ld_step("alu",  4'd0, 2'd0, 32'h1234, 32'h00001234);
        ld_step("sel6", 4'd6, 2'd1, 32'h5678, 32'h00005678);
        bus.in_valid_i = 1'b0;
        tick();
        chk("ld_drain", 64'(bus.out_valid_o), 64'd0);

        // Async reset with two entries held, mid-cycle
        bus.out_ready_i = 1'b0;
        drive(1'b1, 5'd12, 32'h40, 2'd0, 4'd0);
        tick();
        drive(1'b1, 5'd13, 32'h41, 2'd0, 4'd0);
        tick();
        bus.in_valid_i = 1'b0;
        chk("ar_full", 64'(bus.in_ready_o), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.out_valid_o), 64'd0);
        chk("ar_we", 64'(bus.we_o), 64'd0);
        chk("ar_wa", 64'(bus.wa_o), 64'd0);
        #2;
        rst = 1'b1;
        drive(1'b1, 5'd14, 32'h50, 2'd0, 4'd0);
        tick();
        bus.in_valid_i = 1'b0;
        chk("ar_first_vld", 64'(bus.out_valid_o), 64'd1);
        chk("ar_first_wa", 64'(bus.wa_o), 64'd14);
        chk("ar_first_wb", 64'(bus.wb_data_o), 64'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
